seq_restoring_divider: RTL

//  Multi-cycle restoring divider, the inverse of the 4-bit MAC datapath: it splits an
//  8-bit accumulated value back into quotient and remainder by a 4-bit divisor.

---
 rtl/seq_restoring_divider.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, MSB first, with
// valid/ready handshakes on the operand and result sides.
module seq_restoring_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero,
  output logic          busy,
  output logic [1:0]    dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // The producer holds valid and its data until that edge, and the consumer
  // may raise or drop ready freely.

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [VW-1:0] prem_q, prem_d;
  logic [DW-1:0] qwork_q, qwork_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [VW:0]   trial;
  logic [VW-1:0] diff;
  logic [VW-1:0] prem_next;
  logic [DW-1:0] qnext;
  logic          ge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      qwork_q <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      qwork_q <= qwork_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // The partial remainder is always < divisor, so VW bits hold it; only the
  // shifted trial value needs the extra bit. The difference is < 2^VW, so
  // its low VW bits are exact.
  always_comb begin
    trial     = {prem_q, dvd_q[count_q]};
    ge        = (trial >= {1'b0, dvs_q});
    diff      = trial[VW-1:0] - dvs_q;
    prem_next = ge ? diff : trial[VW-1:0];
    qnext     = qwork_q;
    qnext[count_q] = ge;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    qwork_d = qwork_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          count_d = CW'(DW - 1);
          prem_d  = '0;
          qwork_d = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        // A zero divisor spends a single cycle here so its result lands one
        // edge after acceptance.
        if (dvs_q == '0) begin
          quot_d  = '1;
          rem_d   = '0;
          dbz_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          prem_d  = prem_next;
          qwork_d = qnext;
          if (count_q == '0) begin
            quot_d  = qnext;
            rem_d   = prem_next;
            dbz_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            count_d = count_q - CW'(1);
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign dbg_state_o = state_q;

endmodule
